// File: rtl/bc_mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
// The bus widths below match the core's external memory port.
package bc_pkg;

   localparam int BC_DATA_W = 32;
   localparam int BC_ADDR_W = 32;
   localparam int BC_BE_W   = BC_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_e;

   typedef struct packed {
      logic                 we;
      logic [BC_BE_W-1:0]   be;
      logic [BC_ADDR_W-1:0] addr;
      logic [BC_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/bc_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// The master view belongs to the arbiter; the slave view to the stages and the memory.
interface bc_mem_arbiter_if
   import bc_pkg::*;
#(
   parameter int DATA_WIDTH = BC_DATA_W,
   parameter int ADDR_WIDTH = BC_ADDR_W
);

   logic                    i_if_req;
   logic [ADDR_WIDTH-1:0]   i_if_addr;
   logic                    o_if_gnt;
   logic                    o_if_rvalid;
   logic [DATA_WIDTH-1:0]   o_if_rdata;

   logic                    i_ls_req;
   logic                    i_ls_we;
   logic [DATA_WIDTH/8-1:0] i_ls_be;
   logic [ADDR_WIDTH-1:0]   i_ls_addr;
   logic [DATA_WIDTH-1:0]   i_ls_wdata;
   logic                    o_ls_gnt;
   logic                    o_ls_rvalid;
   logic [DATA_WIDTH-1:0]   o_ls_rdata;

   logic                    o_mem_req;
   logic                    o_mem_we;
   logic [DATA_WIDTH/8-1:0] o_mem_be;
   logic [ADDR_WIDTH-1:0]   o_mem_addr;
   logic [DATA_WIDTH-1:0]   o_mem_wdata;
   logic                    i_mem_gnt;
   logic                    i_mem_rvalid;
   logic [DATA_WIDTH-1:0]   i_mem_rdata;

   modport master (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
      output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );

   modport slave (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
      input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );

endinterface

// File: rtl/bc_arb_pick.sv
// Priority select (load/store first) with a saturating starvation guard for fetch.
// The counter only moves on cycles where i_arb says an arbitration really happens.
module bc_arb_pick
   import bc_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_if_req,
   input  logic       i_ls_req,
   input  logic       i_arb,
   output owner_e     o_winner,
   output logic [1:0] o_gnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;
   logic       force_if;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      force_if = (starve_q == LIMIT);
      o_winner = OWN_LS;
      if (i_if_req && (force_if || !i_ls_req)) o_winner = OWN_IF;
      o_gnt = 2'b00;
      if (i_arb) begin
         if (o_winner == OWN_IF) o_gnt[0] = i_if_req;
         else                    o_gnt[1] = i_ls_req;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_q <= '0;
      end else if (i_arb) begin
         if (!i_if_req || o_winner == OWN_IF) starve_q <= '0;
         else if (starve_q != LIMIT)          starve_q <= starve_q + 4'd1;
      end
   end

endmodule

// File: rtl/bc_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one outstanding transaction, response routed back to the captured owner.
module bc_mem_arbiter
   import bc_pkg::*;
#(
   parameter int DATA_WIDTH   = BC_DATA_W,
   parameter int ADDR_WIDTH   = BC_ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   bc_mem_arbiter_if.master   bus
);

   localparam int BE_W = DATA_WIDTH / 8;

   state_e     state_q, state_d;
   owner_e     owner_q;
   owner_e     winner;
   mem_req_t   hold_q;
   logic       ready_q;
   logic       arb;
   logic       resp;
   logic [1:0] gnt;

   // Held low through reset and the first cycle after release to keep every output quiet.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ready_q <= 1'b0;
      else       ready_q <= 1'b1;
   end

   assign arb = ready_q && (state_q == ST_IDLE);

   bc_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_if_req (bus.i_if_req),
      .i_ls_req (bus.i_ls_req),
      .i_arb    (arb),
      .o_winner (winner),
      .o_gnt    (gnt)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         owner_q <= OWN_IF;
         hold_q  <= '0;
      end else if (|gnt) begin
         owner_q <= winner;
         if (winner == OWN_LS)
            hold_q <= '{we: bus.i_ls_we, be: bus.i_ls_be, addr: bus.i_ls_addr, wdata: bus.i_ls_wdata};
         else
            hold_q <= '{we: 1'b0, be: {BE_W{1'b1}}, addr: bus.i_if_addr, wdata: '0};
      end
   end

   always_comb begin
      state_d         = state_q;
      resp            = 1'b0;
      bus.o_if_gnt    = 1'b0;
      bus.o_ls_gnt    = 1'b0;
      bus.o_if_rvalid = 1'b0;
      bus.o_ls_rvalid = 1'b0;
      bus.o_if_rdata  = {DATA_WIDTH{1'b0}};
      bus.o_ls_rdata  = {DATA_WIDTH{1'b0}};
      bus.o_mem_req   = 1'b0;
      bus.o_mem_we    = 1'b0;
      bus.o_mem_be    = '0;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;

      case (state_q)
         ST_IDLE: begin
            bus.o_if_gnt = gnt[0];
            bus.o_ls_gnt = gnt[1];
            if (|gnt) state_d = ST_REQ;
         end
         ST_REQ: begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_we    = hold_q.we;
            bus.o_mem_be    = hold_q.be;
            bus.o_mem_addr  = hold_q.addr[ADDR_WIDTH-1:0];
            bus.o_mem_wdata = hold_q.wdata;
            // A response in the grant cycle finishes the transaction without visiting ST_RESP.
            if (bus.i_mem_gnt) begin
               resp    = bus.i_mem_rvalid;
               state_d = bus.i_mem_rvalid ? ST_IDLE : ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.i_mem_rvalid) begin
               resp    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (resp) begin
         if (owner_q == OWN_LS) begin
            bus.o_ls_rvalid = 1'b1;
            bus.o_ls_rdata  = bus.i_mem_rdata;
         end else begin
            bus.o_if_rvalid = 1'b1;
            bus.o_if_rdata  = bus.i_mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_bc_mem_arbiter.sv
// Directed bench for bc_mem_arbiter: inputs change 1 ns after the rising edge,
// outputs are compared 2 ns later, well clear of either clock edge.
module tb_bc_mem_arbiter;
   import bc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   bc_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   bc_mem_arbiter #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .STARVE_LIMIT (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic any_out();
      return |{bus.o_if_gnt, bus.o_if_rvalid, bus.o_if_rdata,
               bus.o_ls_gnt, bus.o_ls_rvalid, bus.o_ls_rdata,
               bus.o_mem_req, bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      bus.i_if_req     = 1'b0;
      bus.i_if_addr    = '0;
      bus.i_ls_req     = 1'b0;
      bus.i_ls_we      = 1'b0;
      bus.i_ls_be      = '0;
      bus.i_ls_addr    = '0;
      bus.i_ls_wdata   = '0;
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = '0;
   endtask

   task automatic ls_drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
      bus.i_ls_req   = 1'b1;
      bus.i_ls_we    = we;
      bus.i_ls_be    = be;
      bus.i_ls_addr  = addr;
      bus.i_ls_wdata = wdata;
   endtask

   logic [1:0] starve_exp [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

   initial begin
      rst = 1'b1;
      clear_inputs();
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'h100;
      settle();
      check("reset_outputs_zero", 64'(any_out()), 64'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      settle();
      check("release_cycle_outputs_zero", 64'(any_out()), 64'd0);

      // Single fetch: gnt C0, mem_req C1, response C3.
      next_cycle(); settle();
      check("t1_if_gnt", 64'(bus.o_if_gnt), 64'd1);
      check("t1_ls_gnt", 64'(bus.o_ls_gnt), 64'd0);
      next_cycle();
      bus.i_if_req  = 1'b0;
      bus.i_mem_gnt = 1'b1;
      settle();
      check("t1_mem_req", 64'(bus.o_mem_req), 64'd1);
      check("t1_mem_addr", 64'(bus.o_mem_addr), 64'h100);
      check("t1_mem_we", 64'(bus.o_mem_we), 64'd0);
      check("t1_mem_be", 64'(bus.o_mem_be), 64'hF);
      check("t1_mem_wdata", 64'(bus.o_mem_wdata), 64'd0);
      next_cycle();
      bus.i_mem_gnt = 1'b0;
      settle();
      check("t1_resp_wait_mem_req", 64'(bus.o_mem_req), 64'd0);
      check("t1_resp_wait_rvalid", 64'(bus.o_if_rvalid), 64'd0);
      next_cycle();
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'hDEADBEEF;
      settle();
      check("t1_if_rvalid", 64'(bus.o_if_rvalid), 64'd1);
      check("t1_if_rdata", 64'(bus.o_if_rdata), 64'hDEADBEEF);
      check("t1_ls_rvalid", 64'(bus.o_ls_rvalid), 64'd0);
      check("t1_ls_rdata", 64'(bus.o_ls_rdata), 64'd0);

      // Write with memory gnt and ack in the same cycle.
      next_cycle();
      clear_inputs();
      ls_drive(1'b1, 4'h3, 32'h2000, 32'h1234ABCD);
      settle();
      check("t5_ls_gnt", 64'(bus.o_ls_gnt), 64'd1);
      next_cycle();
      bus.i_ls_req     = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h0;
      settle();
      check("t5_mem_we", 64'(bus.o_mem_we), 64'd1);
      check("t5_mem_be", 64'(bus.o_mem_be), 64'h3);
      check("t5_mem_addr", 64'(bus.o_mem_addr), 64'h2000);
      check("t5_mem_wdata", 64'(bus.o_mem_wdata), 64'h1234ABCD);
      check("t5_ls_rvalid", 64'(bus.o_ls_rvalid), 64'd1);
      check("t5_if_rvalid", 64'(bus.o_if_rvalid), 64'd0);

      // Simultaneous requests: load/store first, fetch on the next idle cycle.
      next_cycle();
      clear_inputs();
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'h300;
      ls_drive(1'b0, 4'hF, 32'h400, 32'h0);
      settle();
      check("t2_ls_gnt_first", 64'(bus.o_ls_gnt), 64'd1);
      check("t2_if_gnt_first", 64'(bus.o_if_gnt), 64'd0);
      next_cycle();
      bus.i_ls_req  = 1'b0;
      bus.i_mem_gnt = 1'b1;
      settle();
      check("t2_mem_addr_ls", 64'(bus.o_mem_addr), 64'h400);
      check("t2_no_gnt_in_req", 64'({bus.o_ls_gnt, bus.o_if_gnt}), 64'd0);
      next_cycle();
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h55AA55AA;
      settle();
      check("t2_ls_rdata", 64'(bus.o_ls_rdata), 64'h55AA55AA);
      check("t2_if_rvalid_quiet", 64'(bus.o_if_rvalid), 64'd0);
      check("t2_no_gnt_in_resp", 64'({bus.o_ls_gnt, bus.o_if_gnt}), 64'd0);
      next_cycle();
      bus.i_mem_rvalid = 1'b0;
      settle();
      check("t2_if_gnt_second", 64'(bus.o_if_gnt), 64'd1);
      next_cycle();
      bus.i_if_req     = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h77;
      settle();
      check("t2_mem_addr_if", 64'(bus.o_mem_addr), 64'h300);
      check("t2_if_rdata", 64'(bus.o_if_rdata), 64'h77);

      // Memory stall with a spurious rvalid, fetch waiting throughout.
      next_cycle();
      clear_inputs();
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'h900;
      ls_drive(1'b1, 4'hC, 32'h500, 32'hCAFEF00D);
      settle();
      check("t4_ls_gnt", 64'(bus.o_ls_gnt), 64'd1);
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         bus.i_ls_req     = 1'b0;
         bus.i_mem_rvalid = (c == 2);
         settle();
         check($sformatf("t4_stall%0d_req", c), 64'(bus.o_mem_req), 64'd1);
         check($sformatf("t4_stall%0d_fields", c),
               64'({bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr[15:0], bus.o_mem_wdata}),
               {27'd0, 1'b1, 4'hC, 16'h0500, 32'hCAFEF00D} & 64'h1F_FFFF_FFFF_FFFF);
         check($sformatf("t4_stall%0d_nogr_norv", c),
               64'({bus.o_if_gnt, bus.o_ls_gnt, bus.o_ls_rvalid, bus.o_if_rvalid}), 64'd0);
      end
      next_cycle();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      settle();
      check("t4_gnt_cycle_req", 64'(bus.o_mem_req), 64'd1);
      next_cycle();
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      settle();
      check("t4_ls_ack", 64'(bus.o_ls_rvalid), 64'd1);
      next_cycle();
      bus.i_mem_rvalid = 1'b0;
      settle();
      check("t4_if_gnt_after", 64'(bus.o_if_gnt), 64'd1);
      next_cycle();
      bus.i_if_req     = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h900D;
      settle();
      check("t4_if_rdata", 64'(bus.o_if_rdata), 64'h900D);

      // Starvation guard: both requesters continuously busy.
      next_cycle();
      clear_inputs();
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'hA00;
      ls_drive(1'b0, 4'hF, 32'hB00, 32'h0);
      for (int k = 0; k < 6; k++) begin
         bus.i_mem_gnt    = 1'b0;
         bus.i_mem_rvalid = 1'b0;
         settle();
         check($sformatf("t3_grant%0d", k), 64'({bus.o_ls_gnt, bus.o_if_gnt}), 64'(starve_exp[k]));
         next_cycle();
         bus.i_mem_gnt = 1'b1;
         next_cycle();
         bus.i_mem_gnt    = 1'b0;
         bus.i_mem_rvalid = 1'b1;
         bus.i_mem_rdata  = 32'(k);
         settle();
         check($sformatf("t3_resp%0d_owner", k), 64'({bus.o_ls_rvalid, bus.o_if_rvalid}),
               64'(starve_exp[k]));
         next_cycle();
      end

      // Reset while waiting for the response.
      clear_inputs();
      ls_drive(1'b0, 4'hF, 32'h600, 32'h0);
      settle();
      check("t6_ls_gnt", 64'(bus.o_ls_gnt), 64'd1);
      next_cycle();
      bus.i_ls_req  = 1'b0;
      bus.i_mem_gnt = 1'b1;
      next_cycle();
      bus.i_mem_gnt = 1'b0;
      rst = 1'b1;
      settle();
      check("t6_outputs_in_reset", 64'(any_out()), 64'd0);
      next_cycle();
      rst = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'hBAD;
      settle();
      check("t6_release_outputs", 64'(any_out()), 64'd0);
      next_cycle();
      settle();
      check("t6_late_rvalid_ignored", 64'({bus.o_ls_rvalid, bus.o_if_rvalid}), 64'd0);
      next_cycle();
      bus.i_mem_rvalid = 1'b0;
      bus.i_if_req     = 1'b1;
      bus.i_if_addr    = 32'h700;
      settle();
      check("t6_next_if_gnt", 64'(bus.o_if_gnt), 64'd1);
      next_cycle();
      bus.i_if_req     = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h1234;
      settle();
      check("t6_next_mem_addr", 64'(bus.o_mem_addr), 64'h700);
      check("t6_next_if_rdata", 64'({bus.o_if_rvalid, bus.o_if_rdata}), 64'h1_0000_1234);
      next_cycle();
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
